// File: rtl/esp_rx_pkg.sv
// Shared types and constants for the ESP link receiver: sync byte, FSM state
// encodings and the FIFO pointer width helper.
package esp_rx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHK     = 2'd3
  } parse_state_t;

  // One extra MSB beyond the address lets full and empty be told apart on wrap.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/esp_uart_byte_rx.sv
// 8N1 UART byte receiver: 2-flop rxd synchroniser, start-bit glitch rejection,
// mid-bit sampling; emits one-cycle byte_valid or framing_err pulses.
module esp_uart_byte_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err
);
  import esp_rx_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1_q, sync2_q, prev_q;
  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             byte_valid_q, byte_valid_d;
  logic             framing_err_q, framing_err_d;

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign framing_err = framing_err_q;

  // Synchroniser plus one delayed copy for falling-edge detection; idle line is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= 3'd0;
      shift_q       <= 8'h00;
      byte_data_q   <= 8'h00;
      byte_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      framing_err_q <= framing_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = 1'b0;
    framing_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = 3'd0;
        if (prev_q && !sync2_q) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        // A line back high at mid start bit was only a glitch.
        if (cnt_q == HALF_BIT) begin
          cnt_d = '0;
          if (sync2_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_BIT) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_BIT) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sync2_q) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
          end else begin
            framing_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/esp_packet_rx.sv
// ESP link packet receiver: frames A5/LEN/payload/CHK packets into a FIFO and
// exposes only checksum-verified bytes. Optional inter-byte timeout: ESP_RX_TIMEOUT_EN.
module esp_packet_rx #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int MAX_LEN      = 32,
  parameter int FIFO_DEPTH   = 64,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rxd,
  output logic [7:0]  pkt_data,
  output logic        pkt_last,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic        err_framing,
  output logic        err_checksum,
  output logic        err_drop,
  output logic [15:0] pkt_count
);
  import esp_rx_pkg::*;

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int PTR_W        = ptr_width(FIFO_DEPTH);
  localparam int AW           = PTR_W - 1;
  localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(FIFO_DEPTH);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  logic [7:0] byte_data_s;
  logic       byte_valid_s, framing_err_s;

  esp_uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk        (clk),
    .reset_n    (reset_n),
    .rxd        (rxd),
    .byte_data  (byte_data_s),
    .byte_valid (byte_valid_s),
    .framing_err(framing_err_s)
  );

  parse_state_t     pstate_q, pstate_d;
  logic [7:0]       len_q, len_d, cnt_q, cnt_d, sum_q, sum_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]      pkt_count_q, pkt_count_d;
  logic [7:0]       pkt_data_q, pkt_data_d;
  logic             pkt_last_q, pkt_last_d, pkt_valid_q, pkt_valid_d;
  logic             err_framing_q, err_framing_d;
  logic             err_checksum_q, err_checksum_d;
  logic             err_drop_q, err_drop_d;
  logic [8:0]       mem_q [FIFO_DEPTH];
  logic             wr_en_s, full_s, last_s, tmo_hit_s;
  logic [8:0]       wr_word_s;
  logic [PTR_W-1:0] occ_s, free_s;

  assign pkt_data     = pkt_data_q;
  assign pkt_last     = pkt_last_q;
  assign pkt_valid    = pkt_valid_q;
  assign err_framing  = err_framing_q;
  assign err_checksum = err_checksum_q;
  assign err_drop     = err_drop_q;
  assign pkt_count    = pkt_count_q;

  // Space is measured from the speculative write pointer so uncommitted bytes count as used.
  assign occ_s  = wr_ptr_q - rd_ptr_q;
  assign free_s = DEPTH_P - occ_s;
  assign full_s = (occ_s == DEPTH_P);
  assign last_s = ((cnt_q + 8'd1) == len_q);

`ifdef ESP_RX_TIMEOUT_EN
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    if (byte_valid_s || framing_err_s || (pstate_q == HUNT)) begin
      tmo_cnt_d = 32'd0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= 32'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign tmo_hit_s = (pstate_q != HUNT) && (tmo_cnt_q == TMO_LIMIT);
`else
  assign tmo_hit_s = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_word_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pstate_q       <= HUNT;
      len_q          <= 8'h00;
      cnt_q          <= 8'h00;
      sum_q          <= 8'h00;
      wr_ptr_q       <= '0;
      cmt_ptr_q      <= '0;
      rd_ptr_q       <= '0;
      pkt_count_q    <= 16'h0000;
      pkt_data_q     <= 8'h00;
      pkt_last_q     <= 1'b0;
      pkt_valid_q    <= 1'b0;
      err_framing_q  <= 1'b0;
      err_checksum_q <= 1'b0;
      err_drop_q     <= 1'b0;
    end else begin
      pstate_q       <= pstate_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      sum_q          <= sum_d;
      wr_ptr_q       <= wr_ptr_d;
      cmt_ptr_q      <= cmt_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      pkt_count_q    <= pkt_count_d;
      pkt_data_q     <= pkt_data_d;
      pkt_last_q     <= pkt_last_d;
      pkt_valid_q    <= pkt_valid_d;
      err_framing_q  <= err_framing_d;
      err_checksum_q <= err_checksum_d;
      err_drop_q     <= err_drop_d;
    end
  end

  always_comb begin
    pstate_d       = pstate_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    sum_d          = sum_q;
    wr_ptr_d       = wr_ptr_q;
    cmt_ptr_d      = cmt_ptr_q;
    pkt_count_d    = pkt_count_q;
    err_framing_d  = 1'b0;
    err_checksum_d = 1'b0;
    err_drop_d     = 1'b0;
    wr_en_s        = 1'b0;
    wr_word_s      = 9'h000;

    if (pkt_valid_q && pkt_ready) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Rollback only rewinds to the commit pointer, which never trails the reader.
    if (framing_err_s) begin
      pstate_d      = HUNT;
      wr_ptr_d      = cmt_ptr_q;
      err_framing_d = 1'b1;
    end else if (byte_valid_s) begin
      case (pstate_q)
        HUNT: begin
          if (byte_data_s == SYNC_BYTE) begin
            pstate_d = LEN;
          end else begin
            pstate_d = HUNT;
          end
        end
        LEN: begin
          if ((byte_data_s == 8'h00) || (byte_data_s > MAX_LEN_B) ||
              ({8'h00, byte_data_s} > 16'(free_s))) begin
            err_drop_d = 1'b1;
            pstate_d   = HUNT;
          end else begin
            len_d    = byte_data_s;
            sum_d    = byte_data_s;
            cnt_d    = 8'h00;
            pstate_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!full_s) begin
            wr_en_s   = 1'b1;
            wr_word_s = {last_s, byte_data_s};
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
          end else begin
            wr_en_s = 1'b0;
          end
          sum_d = sum_q + byte_data_s;
          cnt_d = cnt_q + 8'd1;
          if (last_s) begin
            pstate_d = CHK;
          end else begin
            pstate_d = PAYLOAD;
          end
        end
        CHK: begin
          if (8'(sum_q + byte_data_s) == 8'h00) begin
            cmt_ptr_d   = wr_ptr_q;
            pkt_count_d = pkt_count_q + 16'd1;
          end else begin
            wr_ptr_d       = cmt_ptr_q;
            err_checksum_d = 1'b1;
          end
          pstate_d = HUNT;
        end
        default: begin
          pstate_d = HUNT;
        end
      endcase
    end else if (tmo_hit_s) begin
      pstate_d   = HUNT;
      wr_ptr_d   = cmt_ptr_q;
      err_drop_d = 1'b1;
    end else begin
      pstate_d = pstate_q;
    end

    // Output stage looks ahead at next-cycle pointers; committed entries are never rewritten.
    pkt_valid_d = (rd_ptr_d != cmt_ptr_d);
    if (pkt_valid_d) begin
      {pkt_last_d, pkt_data_d} = mem_q[rd_ptr_d[AW-1:0]];
    end else begin
      pkt_last_d = 1'b0;
      pkt_data_d = 8'h00;
    end
  end

endmodule

// File: tb/tb_esp_packet_rx.sv
// Self-checking bench for esp_packet_rx: table-driven single-packet vectors plus
// directed sequences for backpressure/wrap, framing, glitch, reset and timeout.
module tb_esp_packet_rx;
  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rxd = 1'b1;
  logic        pkt_ready = 1'b0;
  logic [7:0]  pkt_data;
  logic        pkt_last, pkt_valid;
  logic        err_framing, err_checksum, err_drop;
  logic [15:0] pkt_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  int n_fr = 0, n_cs = 0, n_drop = 0;
  logic [8:0] out_q[$];

  typedef struct {
    logic [63:0] tx;
    int          ntx;
    logic [31:0] exp;
    int          nexp;
    int          dcs;
    int          ddrop;
    int          dcnt;
  } vec_t;

  always #5 clk = ~clk;

  esp_packet_rx #(
    .CLK_HZ(1000000), .BAUD(100000), .MAX_LEN(32), .FIFO_DEPTH(64), .TIMEOUT_BITS(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd),
    .pkt_data(pkt_data), .pkt_last(pkt_last), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .err_framing(err_framing), .err_checksum(err_checksum), .err_drop(err_drop),
    .pkt_count(pkt_count)
  );

  always @(negedge clk) begin
    if (reset_n) begin
      if (pkt_valid && pkt_ready) out_q.push_back({pkt_last, pkt_data});
      if (err_framing) n_fr++;
      if (err_checksum) n_cs++;
      if (err_drop) n_drop++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(posedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(posedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] first);
    logic [7:0] sum, b;
    sum = 8'(len);
    send_byte(8'hA5, 1'b1);
    send_byte(8'(len), 1'b1);
    for (int i = 0; i < len; i++) begin
      b = first + 8'(i);
      sum = sum + b;
      send_byte(b, 1'b1);
    end
    send_byte(8'h00 - sum, 1'b1);
  endtask

  // Expects n bytes first, first+1, ... after index base, last on every pkt_len-th byte.
  task automatic check_run(input string name, input int base, input int n,
                           input logic [7:0] first, input int pkt_len);
    int got;
    got = out_q.size() - base;
    check({name, "_nout"}, got, n);
    for (int j = 0; j < n && j < got; j++) begin
      check($sformatf("%s_data%0d", name, j), out_q[base + j][7:0], first + 8'(j));
      check($sformatf("%s_last%0d", name, j), out_q[base + j][8], ((j + 1) % pkt_len) == 0);
    end
  endtask

  initial begin
    vec_t vecs[7];
    int base, fr0, cs0, dr0, n;
    vecs[0] = '{tx: 64'h0000_9D30_2010_03A5, ntx: 6, exp: 32'h0030_2010, nexp: 3, dcs: 0, ddrop: 0, dcnt: 1};
    vecs[1] = '{tx: 64'h0000_0000_2211_02A5, ntx: 5, exp: 32'h0,         nexp: 0, dcs: 1, ddrop: 0, dcnt: 0};
    vecs[2] = '{tx: 64'h0000_0000_807F_01A5, ntx: 4, exp: 32'h0000_007F, nexp: 1, dcs: 0, ddrop: 0, dcnt: 1};
    vecs[3] = '{tx: 64'h00FB_0201_02A5_FF00, ntx: 7, exp: 32'h0000_0201, nexp: 2, dcs: 0, ddrop: 0, dcnt: 1};
    vecs[4] = '{tx: 64'h0000_0000_0000_00A5, ntx: 2, exp: 32'h0,         nexp: 0, dcs: 0, ddrop: 1, dcnt: 0};
    vecs[5] = '{tx: 64'h0000_0000_0000_21A5, ntx: 2, exp: 32'h0,         nexp: 0, dcs: 0, ddrop: 1, dcnt: 0};
    vecs[6] = '{tx: 64'h0000_00FA_0501_A5A5, ntx: 5, exp: 32'h0,         nexp: 0, dcs: 0, ddrop: 1, dcnt: 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", pkt_valid, 1'b0);
    check("rst_data", pkt_data, 8'h00);
    check("rst_last", pkt_last, 1'b0);
    check("rst_count", pkt_count, 16'h0000);
    check("rst_errs", {err_framing, err_checksum, err_drop}, 3'b000);
    reset_n = 1'b1;
    pkt_ready = 1'b1;
    repeat (5) @(posedge clk);

    for (int v = 0; v < 7; v++) begin
      base = out_q.size(); fr0 = n_fr; cs0 = n_cs; dr0 = n_drop;
      for (int k = 0; k < vecs[v].ntx; k++) send_byte(vecs[v].tx[8*k +: 8], 1'b1);
      repeat (40) @(posedge clk);
      @(negedge clk);
      exp_count += vecs[v].dcnt;
      n = out_q.size() - base;
      check($sformatf("v%0d_nout", v), n, vecs[v].nexp);
      for (int k = 0; k < vecs[v].nexp && k < n; k++) begin
        check($sformatf("v%0d_data%0d", v, k), out_q[base + k][7:0], vecs[v].exp[8*k +: 8]);
        check($sformatf("v%0d_last%0d", v, k), out_q[base + k][8], k == vecs[v].nexp - 1);
      end
      check($sformatf("v%0d_count", v), pkt_count, exp_count);
      check($sformatf("v%0d_cs", v), n_cs - cs0, vecs[v].dcs);
      check($sformatf("v%0d_drop", v), n_drop - dr0, vecs[v].ddrop);
      check($sformatf("v%0d_fr", v), n_fr - fr0, 0);
    end

    // Backpressure: 60 bytes held, a LEN=10 packet cannot fit in the 4 free entries.
    pkt_ready = 1'b0;
    base = out_q.size(); dr0 = n_drop;
    send_pkt(30, 8'd1);
    send_pkt(30, 8'd31);
    send_pkt(10, 8'd1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    exp_count += 2;
    check("bp_drop", n_drop - dr0, 1);
    check("bp_count", pkt_count, exp_count);
    check("bp_valid", pkt_valid, 1'b1);
    check("bp_data", pkt_data, 8'd1);
    check("bp_last", pkt_last, 1'b0);
    repeat (5) @(negedge clk);
    check("bp_hold_data", pkt_data, 8'd1);
    check("bp_hold_valid", pkt_valid, 1'b1);
    pkt_ready = 1'b1;
    repeat (80) @(posedge clk);
    @(negedge clk);
    check_run("bp", base, 60, 8'd1, 30);
    check("bp_empty", pkt_valid, 1'b0);

    base = out_q.size();
    send_pkt(30, 8'd100);
    repeat (50) @(posedge clk);
    @(negedge clk);
    exp_count += 1;
    check_run("wrap", base, 30, 8'd100, 30);
    base = out_q.size();
    send_pkt(32, 8'd140);
    repeat (50) @(posedge clk);
    @(negedge clk);
    exp_count += 1;
    check_run("maxlen", base, 32, 8'd140, 32);
    check("maxlen_count", pkt_count, exp_count);

    // Framing error mid-payload, then an idle-line glitch, then a clean packet.
    base = out_q.size(); fr0 = n_fr; cs0 = n_cs; dr0 = n_drop;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("fr_pulse", n_fr - fr0, 1);
    check("fr_noout", out_q.size() - base, 0);
    check("fr_valid", pkt_valid, 1'b0);
    @(posedge clk);
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    rxd = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("gl_fr", n_fr - fr0, 1);
    check("gl_errs", (n_cs - cs0) + (n_drop - dr0), 0);
    send_pkt(2, 8'h40);
    repeat (40) @(posedge clk);
    @(negedge clk);
    exp_count += 1;
    check_run("fr_good", base, 2, 8'h40, 2);
    check("fr_count", pkt_count, exp_count);

    // Reset while a committed byte waits and another packet is mid-payload.
    pkt_ready = 1'b0;
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1);
    send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h10, 1'b1);
    @(negedge clk);
    check("pre_rst_valid", pkt_valid, 1'b1);
    check("pre_rst_data", pkt_data, 8'h55);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", pkt_valid, 1'b0);
    check("mid_rst_data", pkt_data, 8'h00);
    check("mid_rst_last", pkt_last, 1'b0);
    check("mid_rst_count", pkt_count, 16'h0000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_count = 0;
    pkt_ready = 1'b1;
    base = out_q.size();
    repeat (5) @(posedge clk);
    send_pkt(3, 8'h10);
    repeat (40) @(posedge clk);
    @(negedge clk);
    exp_count += 1;
    check_run("post_rst", base, 3, 8'h10, 3);
    check("post_rst_count", pkt_count, exp_count);

`ifdef ESP_RX_TIMEOUT_EN
    base = out_q.size(); dr0 = n_drop;
    send_byte(8'hA5, 1'b1); send_byte(8'h04, 1'b1); send_byte(8'h01, 1'b1);
    repeat (250) @(posedge clk);
    @(negedge clk);
    check("tmo_early", n_drop - dr0, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("tmo_drop", n_drop - dr0, 1);
    send_pkt(2, 8'h60);
    repeat (40) @(posedge clk);
    @(negedge clk);
    exp_count += 1;
    check_run("tmo_good", base, 2, 8'h60, 2);
    check("tmo_count", pkt_count, exp_count);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/esp_packet_rx.md
Name: esp_packet_rx

Overview:
Fabric-side receiver for the ESP link serial stream. It runs in parallel with the system's esp_uart port and feeds parsed pose/score packets into the Computer_System bridge logic.
- Deserialises 8N1 UART bytes.
- Frames packets of the form 0xA5, LEN, payload, CHK.
- Buffers payload speculatively in a FIFO and exposes only checksum-verified packets on a valid/ready stream.

Parameters:
CLK_HZ, 50000000, fabric clock frequency.
BAUD, 115200, serial rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer division.
MAX_LEN, 32, largest legal LEN value; LEN range is 1..MAX_LEN.
FIFO_DEPTH, 64, payload FIFO entries; power of two, and FIFO_DEPTH >= MAX_LEN.
TIMEOUT_BITS, 32, inter-byte timeout in bit times (used only with the optional feature).

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
rxd  in  1  raw serial line from the ESP; idle high.
pkt_data  out  8  payload byte at the FIFO head.
pkt_last  out  1  marks the final byte of a packet.
pkt_valid  out  1  head byte is committed and available.
pkt_ready  in  1  consumer accepts the head byte.
err_framing  out  1  one-cycle pulse: stop bit sampled low.
err_checksum  out  1  one-cycle pulse: CHK mismatch, packet discarded.
err_drop  out  1  one-cycle pulse: bad LEN, insufficient FIFO space, or timeout.
pkt_count  out  16  committed packets since reset; wraps at 0xFFFF to 0.

Behaviour:
- Interface: single clock `clk`; `reset_n` is asynchronous, active-low. All state clears immediately on reset assertion.
- Reset values:
  - All outputs are 0.
  - Both FIFO pointers and the commit pointer are 0.
  - The rxd synchroniser resets to 1.
  - Both FSMs return to their idle states.
- rxd passes through a 2-flop synchroniser; all sampling uses the synchronised value.
- UART FSM:
  - IDLE: a falling edge goes to START.
  - START: wait CLKS_PER_BIT/2, then resample. If the line is high (glitch), return to IDLE; otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT.
    - Stop bit high: emit byte_valid for 1 cycle.
    - Stop bit low: pulse err_framing, discard the byte, force the parser to HUNT with rollback.
  - Return to IDLE after STOP.
- Parser FSM (advances only on byte_valid):
  - HUNT: a byte equal to 0xA5 goes to LEN; any other byte is ignored.
  - LEN: if the byte is 0 or > MAX_LEN, pulse err_drop and go to HUNT. If free space (DEPTH minus occupancy from the uncommitted write pointer) < LEN, pulse err_drop and go to HUNT. Otherwise latch len, seed sum = LEN, go to PAYLOAD.
  - PAYLOAD: write {last, byte} at the speculative write pointer. last = 1 on the len-th byte. sum += byte (mod 256). After the len-th byte, go to CHK.
  - CHK: if (sum + byte) mod 256 == 0, commit, increment pkt_count, go to HUNT. On mismatch, restore the write pointer to the commit pointer, pulse err_checksum, go to HUNT.
- Commit: the commit pointer takes the write pointer value on the clock edge following the CHK byte. pkt_valid reflects read pointer != commit pointer, so the reader never sees uncommitted bytes.
- Output stream (first-word fall-through):
  - pkt_data and pkt_last are valid whenever pkt_valid is 1.
  - A transfer occurs when pkt_valid && pkt_ready.
  - Data and last are held stable while pkt_valid && !pkt_ready.
  - Latency: the first byte of a packet is presented 1 cycle after commit.
- Simultaneous events:
  - A read and a commit, or a read and a rollback, in the same cycle are both honoured.
  - A rollback never moves pointers past the read pointer.
  - A commit is never lost.
- Full: the space check at LEN guarantees PAYLOAD writes never overflow; no write occurs when the FIFO is full.
- Pointers are log2(DEPTH)+1 bits wide; the MSB distinguishes full from empty on wrap-around.

Optional Feature:
ESP_RX_TIMEOUT_EN
- Defined: a counter reloads on every byte_valid. If the parser sits in LEN, PAYLOAD or CHK for TIMEOUT_BITS*CLKS_PER_BIT cycles with no byte, it rolls back, pulses err_drop and goes to HUNT.
- Undefined: no counter is built, the parser waits indefinitely, and the TIMEOUT_BITS parameter is unused.

Decomposition:
- Package esp_rx_pkg holds:
  - SYNC_BYTE = 8'hA5;
  - the uart_state_t enum {IDLE, START, DATA, STOP};
  - the parse_state_t enum {HUNT, LEN, PAYLOAD, CHK};
  - a function clog2-based pointer width helper.
- Sub-module esp_uart_byte_rx contains the synchroniser, UART FSM and bit counter. It outputs byte_data[7:0], byte_valid and framing_err.
- The parser and FIFO live in the top module.

Test Plan:
All scenarios use CLK_HZ=1000000, BAUD=100000 (10 clks/bit), MAX_LEN=32, FIFO_DEPTH=64.
- Good packet: send A5 03 10 20 30 9D with pkt_ready=1 -> pkt_data 10, 20, 30 with pkt_last on 30; pkt_count=1; no error pulses.
- Bad checksum: send A5 02 11 22 00 -> err_checksum pulses once, pkt_valid stays 0, pkt_count=0. Then send a good packet -> only its bytes appear.
- Backpressure and wrap: pkt_ready=0, send two good LEN=30 packets, then a LEN=10 packet -> LEN=10 packet raises err_drop (free space 4 < 10). Assert pkt_ready -> 60 bytes drain in order, last flags on bytes 30 and 60. Send a further LEN=30 packet -> pointers wrap correctly.
- Framing and glitch: drive a stop bit low mid-PAYLOAD -> err_framing, rollback, no output. Drive a 3-cycle low glitch on idle rxd -> no byte, no error.
- Reset mid-packet: assert reset_n=0 during PAYLOAD -> all outputs 0 immediately. After release, a good packet is received correctly.
- With ESP_RX_TIMEOUT_EN: send A5 04 01 then idle 320 cycles -> err_drop pulse, parser back in HUNT. The next good packet is received.
